// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding request, single-port word memory.
// Handles lane steering, sign/zero extension and misalignment/range faults.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic        accept;
  logic        fault;
  logic        oob;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] sh;
  logic [31:0] ld_c;

  assign accept = (state_q == IDLE) && req_valid;
  assign oob = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

  always_comb begin
    fault = 1'b0;
    if (req_funct3 == 3'd3)
      fault = 1'b1;
    if (req_funct3[2:1] == 2'b11)
      fault = 1'b1;
    if (req_write && req_funct3[2:1] == 2'b10)
      fault = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      fault = 1'b1;
    if (req_funct3 == 3'd2 && req_addr[1:0] != 2'b00)
      fault = 1'b1;
    if (oob)
      fault = 1'b1;
  end

  // Byte/half data is replicated so the enabled lanes always see it.
  always_comb begin
    be_c = 4'b1111;
    wd_c = req_wdata;
    unique case (req_funct3[1:0])
      2'b00: begin
        be_c = 4'b0001 << req_addr[1:0];
        wd_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c = 4'b0011 << req_addr[1:0];
        wd_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = req_wdata;
      end
    endcase
  end

  always_comb begin
    sh   = mem_rdata >> {off_q, 3'b000};
    ld_c = sh;
    unique case (f3_q)
      3'd0:    ld_c = {{24{sh[7]}}, sh[7:0]};
      3'd1:    ld_c = {{16{sh[15]}}, sh[15:0]};
      3'd4:    ld_c = {24'h0, sh[7:0]};
      3'd5:    ld_c = {16'h0, sh[15:0]};
      default: ld_c = sh;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_be     = 4'b0000;
    unique case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          if (fault)
            state_d = RESP;
          else if (req_write)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        mem_be   = be_q;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        state_d = RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_be    = be_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      be_q       <= 4'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else if (accept) begin
      f3_q       <= req_funct3;
      off_q      <= req_addr[1:0];
      be_q       <= be_c;
      mem_addr   <= {2'b00, req_addr[31:2]};
      mem_wdata  <= wd_c;
      resp_rdata <= 32'd0;
      resp_fault <= fault;
    end else if (state_q == CAPTURE) begin
      resp_rdata <= ld_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
// Each task drives one scenario and checks latency, lanes and responses.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read)
      mem_rdata <= mem[mem_addr[5:0]];
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Presents a request at a falling edge; returns 1 time unit after the
  // accepting rising edge, i.e. in cycle+1.
  task automatic send(input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({resp_valid, resp_fault, mem_read, mem_write} !== 4'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b exp 0000",
               {resp_valid, resp_fault, mem_read, mem_write});
    end
    checks++;
    if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== 100'd0) begin
      errors++;
      $display("FAIL rst_data be=%h addr=%h wd=%h rd=%h exp 0",
               mem_be, mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_load_signed_byte();
    send(1'b0, 3'd0, 32'h17, 32'h0);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd5 || mem_be !== 4'b1000) begin
      errors++;
      $display("FAIL lb_strobe rd=%b addr=%h be=%b exp 1/5/1000",
               mem_read, mem_addr, mem_be);
    end
    step();
    checks++;
    if (mem_read !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lb_c2 rd=%b rv=%b exp 0/0", mem_read, resp_valid);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80 ||
        resp_fault !== 1'b0) begin
      errors++;
      $display("FAIL lb_resp rv=%b rd=%h f=%b exp 1/ffffff80/0",
               resp_valid, resp_rdata, resp_fault);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_idle rv=%b rdy=%b exp 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_load_unsigned_half();
    send(1'b0, 3'd5, 32'h16, 32'h0);
    step();
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_80FF ||
        resp_fault !== 1'b0) begin
      errors++;
      $display("FAIL lhu_resp rv=%b rd=%h f=%b exp 1/000080ff/0",
               resp_valid, resp_rdata, resp_fault);
    end
    step();
  endtask

  task automatic test_store_byte();
    send(1'b1, 3'd0, 32'h09, 32'h0000_00AB);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'd2 ||
        mem_be !== 4'b0010 || mem_wdata !== 32'hABAB_ABAB) begin
      errors++;
      $display("FAIL sb_strobe wr=%b rd=%b addr=%h be=%b wd=%h",
               mem_write, mem_read, mem_addr, mem_be, mem_wdata);
    end
    step();
    checks++;
    if (resp_valid !== 1'b1 || resp_fault !== 1'b0 ||
        resp_rdata !== 32'd0 || mem_write !== 1'b0 || mem_be !== 4'b0) begin
      errors++;
      $display("FAIL sb_resp rv=%b f=%b rd=%h wr=%b be=%b exp 1/0/0/0/0",
               resp_valid, resp_fault, resp_rdata, mem_write, mem_be);
    end
    step();
    send(1'b0, 3'd2, 32'h08, 32'h0);
    step();
    step();
    checks++;
    if (resp_rdata !== 32'h1122_AB44) begin
      errors++;
      $display("FAIL sb_readback got %h exp 1122ab44", resp_rdata);
    end
    step();
  endtask

  task automatic test_store_half();
    send(1'b1, 3'd1, 32'h0E, 32'h1234_CAFE);
    checks++;
    if (mem_addr !== 32'd3 || mem_be !== 4'b1100 ||
        mem_wdata !== 32'hCAFE_CAFE) begin
      errors++;
      $display("FAIL sh_lanes addr=%h be=%b wd=%h exp 3/1100/cafecafe",
               mem_addr, mem_be, mem_wdata);
    end
    step();
    step();
    send(1'b0, 3'd1, 32'h0E, 32'h0);
    step();
    step();
    checks++;
    if (resp_rdata !== 32'hFFFF_CAFE) begin
      errors++;
      $display("FAIL lh_readback got %h exp ffffcafe", resp_rdata);
    end
    step();
  endtask

  task automatic test_faults();
    logic        fw [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  ff [5] = '{3'd2, 3'd4, 3'd2, 3'd3, 3'd1};
    logic [31:0] fa [5] = '{32'h06, 32'h10, 32'h100, 32'h0, 32'h05};
    for (int i = 0; i < 5; i++) begin
      send(fw[i], ff[i], fa[i], 32'h5555_5555);
      checks++;
      if (resp_valid !== 1'b1 || resp_fault !== 1'b1 ||
          resp_rdata !== 32'd0 || mem_read !== 1'b0 ||
          mem_write !== 1'b0) begin
        errors++;
        $display("FAIL fault%0d rv=%b f=%b rd=%h r=%b w=%b exp 1/1/0/0/0",
                 i, resp_valid, resp_fault, resp_rdata, mem_read, mem_write);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    send(1'b0, 3'd2, 32'h14, 32'h0);
    step();
    step();
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h80FF_1234 ||
          req_ready !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d rv=%b rd=%h rdy=%b w=%b", c,
                 resp_valid, resp_rdata, req_ready, mem_write);
      end
      step();
    end
    @(negedge clk);
    resp_ready = 1'b1;
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rv=%b rdy=%b w=%b exp 0/1/0",
               resp_valid, req_ready, mem_write);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'd8 || mem_be !== 4'b1111 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bp_second w=%b addr=%h be=%b wd=%h",
               mem_write, mem_addr, mem_be, mem_wdata);
    end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    send(1'b0, 3'd2, 32'h14, 32'h0);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rm_read got %b exp 1", mem_read);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rm_async got %b exp 0", mem_read);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_idle rdy=%b rv=%b exp 1/0", req_ready, resp_valid);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (resp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL rm_quiet%0d rv=%b r=%b w=%b exp 0", c,
                 resp_valid, mem_read, mem_write);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = 32'd0;
    mem[2]     = 32'h1122_3344;
    mem[5]     = 32'h80FF_1234;
    mem_rdata  = 32'd0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    test_reset();
    test_load_signed_byte();
    test_load_unsigned_half();
    test_store_byte();
    test_store_half();
    test_faults();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
